// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave window of N_REGS 32-bit software registers (RW hold, self-clearing pulse or RO status)
// with byte-enable writes, readback and per-register write strobes toward user logic on OPB_Clk.
module opb_register_bank_ppc2simulink #(
    parameter int unsigned             C_OPB_AWIDTH = 32,
    parameter int unsigned             C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_6000,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_60FF,
    parameter int unsigned             N_REGS       = 4,
    parameter logic [N_REGS-1:0]       PULSE_MASK   = '0,
    parameter logic [N_REGS-1:0]       RO_MASK      = '0,
    parameter logic [C_OPB_DWIDTH-1:0] INIT_VAL     = '0
) (
    input  logic                           OPB_Clk,
    input  logic                           OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]        OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]      OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]        OPB_DBus,
    input  logic                           OPB_RNW,
    input  logic                           OPB_select,
    input  logic                           OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]        Sl_DBus,
    output logic                           Sl_xferAck,
    output logic                           Sl_errAck,
    output logic                           Sl_retry,
    output logic                           Sl_toutSup,
    output logic [C_OPB_DWIDTH*N_REGS-1:0] user_data_out,
    output logic [N_REGS-1:0]              user_wr_stb,
    input  logic [C_OPB_DWIDTH*N_REGS-1:0] user_data_in
);

    localparam int unsigned AW    = C_OPB_AWIDTH;
    localparam int unsigned DW    = C_OPB_DWIDTH;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     regs_q [N_REGS];
    logic [DW-1:0]     regs_d [N_REGS];
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [N_REGS-1:0] stb_q, stb_d;

    logic [AW-1:0]    addr;
    logic [AW-1:0]    offset;
    logic [AW-1:0]    word_off;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    wdata;
    logic [NB-1:0]    be;
    logic             hit;
    logic             in_regs;
    logic             accept;
    logic             unused_ok;

    // Big-endian bus vectors land MSB-first, so BE[0]/DBus[0:7] map onto bits 31:24.
    assign addr     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign be       = OPB_BE;
    assign offset   = addr - C_BASEADDR;
    assign word_off = offset >> 2;
    assign idx      = offset[IDX_W+1:2];
    assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign in_regs  = (word_off < AW'(N_REGS));
    assign accept   = (state_q == ST_IDLE) && hit;

    assign unused_ok = ^{OPB_seqAddr, offset, user_data_in};

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Select is ignored in RECOVER so a held request cannot be acked twice in a row.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (hit) state_d = ST_ACK;
            ST_ACK:     state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Register file update, read capture and strobe generation on the IDLE->ACK edge.
    always_comb begin
        rdata_d = '0;
        stb_d   = '0;
        for (int i = 0; i < N_REGS; i++) begin
            regs_d[i] = PULSE_MASK[i] ? '0 : regs_q[i];
            if (accept && in_regs && (idx == IDX_W'(i))) begin
                if (OPB_RNW) begin
                    rdata_d = RO_MASK[i] ? user_data_in[i*DW +: DW] : regs_q[i];
                end else begin
                    stb_d[i] = 1'b1;
                    if (!RO_MASK[i]) begin
                        for (int b = 0; b < NB; b++) begin
                            if (be[b]) regs_d[i][b*8 +: 8] = wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            rdata_q <= '0;
            stb_q   <= '0;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= (PULSE_MASK[i] || RO_MASK[i]) ? '0 : INIT_VAL;
            end
        end else begin
            rdata_q <= rdata_d;
            stb_q   <= stb_d;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        Sl_xferAck    = (state_q == ST_ACK);
        Sl_DBus       = rdata_q;
        user_wr_stb   = stb_q;
        user_data_out = '0;
        for (int i = 0; i < N_REGS; i++) begin
            user_data_out[i*DW +: DW] = regs_q[i];
        end
    end

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed self-checking bench for the OPB register bank: register 0 pulse, register 3 read-only.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h0100_6000;
    localparam logic [31:0] HIGH = 32'h0100_60FF;

    logic          OPB_Clk = 1'b0;
    logic          OPB_Rst;
    logic [0:31]   OPB_ABus;
    logic [0:3]    OPB_BE;
    logic [0:31]   OPB_DBus;
    logic          OPB_RNW;
    logic          OPB_select;
    logic          OPB_seqAddr;
    logic [0:31]   Sl_DBus;
    logic          Sl_xferAck;
    logic          Sl_errAck;
    logic          Sl_retry;
    logic          Sl_toutSup;
    logic [127:0]  user_data_out;
    logic [3:0]    user_wr_stb;
    logic [127:0]  user_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    logic         cap_ack;
    int           cap_lat;
    logic [31:0]  cap_rd;
    logic [127:0] cap_uout;
    logic [3:0]   cap_stb;
    logic         cap_ack_after;
    logic [127:0] cap_uout_after;
    logic [3:0]   cap_stb_after;

    opb_register_bank_ppc2simulink #(
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .N_REGS      (4),
        .PULSE_MASK  (4'b0001),
        .RO_MASK     (4'b1000),
        .INIT_VAL    (32'h0)
    ) dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_out(user_data_out),
        .user_wr_stb  (user_wr_stb),
        .user_data_in (user_data_in)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic bus_idle();
        OPB_select = 1'b0;
        OPB_RNW    = 1'b0;
        OPB_ABus   = 32'h0;
        OPB_BE     = 4'h0;
        OPB_DBus   = 32'h0;
    endtask

    // One transfer started at a negedge; waits at most 4 cycles for the ack, ends two cycles later.
    task automatic opb_xfer(input logic rnw, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] data);
        int n;
        OPB_select = 1'b1;
        OPB_RNW    = rnw;
        OPB_ABus   = addr;
        OPB_BE     = be;
        OPB_DBus   = data;
        cap_ack = 1'b0;
        cap_lat = 0;
        cap_rd  = 32'hx;
        cap_uout = 'x;
        cap_stb  = 'x;
        n = 0;
        while (n < 4 && !cap_ack) begin
            @(negedge OPB_Clk);
            n++;
            if (Sl_xferAck === 1'b1) begin
                cap_ack  = 1'b1;
                cap_lat  = n;
                cap_rd   = Sl_DBus;
                cap_uout = user_data_out;
                cap_stb  = user_wr_stb;
            end
        end
        bus_idle();
        @(negedge OPB_Clk);
        cap_ack_after  = Sl_xferAck;
        cap_uout_after = user_data_out;
        cap_stb_after  = user_wr_stb;
        @(negedge OPB_Clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if (Sl_xferAck !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", Sl_xferAck); end
        n_tests++;
        if (Sl_DBus !== 32'h0) begin n_fail++; $display("FAIL reset_dbus: got %h expected 00000000", Sl_DBus); end
        n_tests++;
        if (user_wr_stb !== 4'h0) begin n_fail++; $display("FAIL reset_stb: got %b expected 0000", user_wr_stb); end
        n_tests++;
        if (user_data_out !== 128'h0) begin n_fail++; $display("FAIL reset_uout: got %h expected 0", user_data_out); end
        for (int i = 0; i < 4; i++) begin
            opb_xfer(1'b1, BASE + 32'(4 * i), 4'hF, 32'h0);
            n_tests++;
            if (!(cap_ack === 1'b1 && cap_lat == 1)) begin
                n_fail++; $display("FAIL reset_read_lat[%0d]: got ack=%b lat=%0d expected ack=1 lat=1", i, cap_ack, cap_lat);
            end
            n_tests++;
            if (cap_rd !== 32'h0) begin n_fail++; $display("FAIL reset_read_data[%0d]: got %h expected 00000000", i, cap_rd); end
            n_tests++;
            if (cap_ack_after !== 1'b0) begin n_fail++; $display("FAIL reset_read_ack_len[%0d]: got %b expected 0", i, cap_ack_after); end
        end
    endtask

    task automatic test_full_write();
        opb_xfer(1'b0, BASE + 32'd8, 4'b1111, 32'hDEAD_BEEF);
        n_tests++;
        if (cap_ack !== 1'b1) begin n_fail++; $display("FAIL full_write_ack: got %b expected 1", cap_ack); end
        n_tests++;
        if (cap_stb !== 4'b0100) begin n_fail++; $display("FAIL full_write_stb: got %b expected 0100", cap_stb); end
        n_tests++;
        if (cap_stb_after !== 4'b0000) begin n_fail++; $display("FAIL full_write_stb_len: got %b expected 0000", cap_stb_after); end
        n_tests++;
        if (cap_uout[95:64] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL full_write_uout: got %h expected deadbeef", cap_uout[95:64]); end
        opb_xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0);
        n_tests++;
        if (cap_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL full_write_readback: got %h expected deadbeef", cap_rd); end
    endtask

    task automatic test_byte_enable();
        opb_xfer(1'b0, BASE + 32'd8, 4'b0101, 32'h1122_3344);
        n_tests++;
        if (cap_uout_after[95:64] !== 32'hDE22_BE44) begin n_fail++; $display("FAIL be_uout: got %h expected de22be44", cap_uout_after[95:64]); end
        opb_xfer(1'b1, BASE + 32'd10, 4'hF, 32'h0);
        n_tests++;
        if (cap_rd !== 32'hDE22_BE44) begin n_fail++; $display("FAIL be_readback: got %h expected de22be44", cap_rd); end
        opb_xfer(1'b0, BASE + 32'd8, 4'b0000, 32'hFFFF_FFFF);
        n_tests++;
        if (cap_stb !== 4'b0100) begin n_fail++; $display("FAIL be_zero_stb: got %b expected 0100", cap_stb); end
        n_tests++;
        if (cap_uout_after[95:64] !== 32'hDE22_BE44) begin n_fail++; $display("FAIL be_zero_keep: got %h expected de22be44", cap_uout_after[95:64]); end
    endtask

    task automatic test_pulse();
        opb_xfer(1'b0, BASE, 4'hF, 32'h5);
        n_tests++;
        if (cap_uout[31:0] !== 32'h5) begin n_fail++; $display("FAIL pulse_visible: got %h expected 00000005", cap_uout[31:0]); end
        n_tests++;
        if (cap_stb !== 4'b0001) begin n_fail++; $display("FAIL pulse_stb: got %b expected 0001", cap_stb); end
        n_tests++;
        if (cap_uout_after[31:0] !== 32'h0) begin n_fail++; $display("FAIL pulse_clear: got %h expected 00000000", cap_uout_after[31:0]); end
        opb_xfer(1'b1, BASE, 4'hF, 32'h0);
        n_tests++;
        if (cap_rd !== 32'h0) begin n_fail++; $display("FAIL pulse_readback: got %h expected 00000000", cap_rd); end
    endtask

    task automatic test_read_only();
        user_data_in = {32'hCAFE_0001, 96'h0};
        opb_xfer(1'b0, BASE + 32'd12, 4'hF, 32'h0);
        n_tests++;
        if (!(cap_ack === 1'b1 && cap_stb === 4'b1000)) begin
            n_fail++; $display("FAIL ro_write: got ack=%b stb=%b expected ack=1 stb=1000", cap_ack, cap_stb);
        end
        opb_xfer(1'b1, BASE + 32'd12, 4'hF, 32'h0);
        n_tests++;
        if (cap_rd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL ro_readback: got %h expected cafe0001", cap_rd); end
        user_data_in = {32'h1234_5678, 96'h0};
        opb_xfer(1'b1, BASE + 32'd12, 4'hF, 32'h0);
        n_tests++;
        if (cap_rd !== 32'h1234_5678) begin n_fail++; $display("FAIL ro_readback2: got %h expected 12345678", cap_rd); end
    endtask

    task automatic test_held_select();
        logic [5:0] ack_mask;
        ack_mask   = '0;
        OPB_select = 1'b1;
        OPB_RNW    = 1'b1;
        OPB_ABus   = BASE + 32'd8;
        OPB_BE     = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge OPB_Clk);
            ack_mask[c] = Sl_xferAck;
        end
        bus_idle();
        @(negedge OPB_Clk);
        n_tests++;
        if (ack_mask !== 6'b001001) begin n_fail++; $display("FAIL held_select_acks: got %b expected 001001", ack_mask); end
    endtask

    task automatic test_out_of_range();
        opb_xfer(1'b1, BASE + 32'd16, 4'hF, 32'h0);
        n_tests++;
        if (!(cap_ack === 1'b1 && cap_lat == 1)) begin
            n_fail++; $display("FAIL oor_read_ack: got ack=%b lat=%0d expected ack=1 lat=1", cap_ack, cap_lat);
        end
        n_tests++;
        if (cap_rd !== 32'h0) begin n_fail++; $display("FAIL oor_read_data: got %h expected 00000000", cap_rd); end
        opb_xfer(1'b0, BASE + 32'hFC, 4'hF, 32'hFFFF_FFFF);
        n_tests++;
        if (!(cap_ack === 1'b1 && cap_stb === 4'b0000)) begin
            n_fail++; $display("FAIL oor_write: got ack=%b stb=%b expected ack=1 stb=0000", cap_ack, cap_stb);
        end
        n_tests++;
        if (cap_uout_after[95:0] !== {32'hDE22_BE44, 64'h0}) begin
            n_fail++; $display("FAIL oor_write_keep: got %h expected de22be440000000000000000", cap_uout_after[95:0]);
        end
    endtask

    task automatic test_outside_window();
        opb_xfer(1'b1, HIGH + 32'd1, 4'hF, 32'h0);
        n_tests++;
        if (cap_ack !== 1'b0) begin n_fail++; $display("FAIL above_window_ack: got %b expected 0", cap_ack); end
        opb_xfer(1'b0, BASE - 32'd4, 4'hF, 32'hFFFF_FFFF);
        n_tests++;
        if (!(cap_ack === 1'b0 && cap_stb_after === 4'b0000)) begin
            n_fail++; $display("FAIL below_window: got ack=%b stb=%b expected ack=0 stb=0000", cap_ack, cap_stb_after);
        end
        n_tests++;
        if (cap_uout_after[95:0] !== {32'hDE22_BE44, 64'h0}) begin
            n_fail++; $display("FAIL below_window_keep: got %h expected de22be440000000000000000", cap_uout_after[95:0]);
        end
    endtask

    task automatic test_reset_mid_ack();
        opb_xfer(1'b0, BASE + 32'd4, 4'hF, 32'hAAAA_5555);
        n_tests++;
        if (cap_uout_after[63:32] !== 32'hAAAA_5555) begin n_fail++; $display("FAIL pre_reset_write: got %h expected aaaa5555", cap_uout_after[63:32]); end
        OPB_select = 1'b1;
        OPB_RNW    = 1'b0;
        OPB_ABus   = BASE + 32'd4;
        OPB_BE     = 4'hF;
        OPB_DBus   = 32'h1234_5678;
        @(negedge OPB_Clk);
        n_tests++;
        if (Sl_xferAck !== 1'b1) begin n_fail++; $display("FAIL mid_ack_enter: got %b expected 1", Sl_xferAck); end
        #1 OPB_Rst = 1'b0;
        #1;
        n_tests++;
        if (Sl_xferAck !== 1'b0) begin n_fail++; $display("FAIL mid_ack_drop: got %b expected 0", Sl_xferAck); end
        n_tests++;
        if (user_data_out !== 128'h0) begin n_fail++; $display("FAIL mid_ack_regs: got %h expected 0", user_data_out); end
        n_tests++;
        if (user_wr_stb !== 4'h0) begin n_fail++; $display("FAIL mid_ack_stb: got %b expected 0000", user_wr_stb); end
        bus_idle();
        @(negedge OPB_Clk);
        @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        @(negedge OPB_Clk);
        opb_xfer(1'b1, BASE + 32'd4, 4'hF, 32'h0);
        n_tests++;
        if (!(cap_ack === 1'b1 && cap_lat == 1 && cap_rd === 32'h0)) begin
            n_fail++; $display("FAIL post_reset_read: got ack=%b lat=%0d data=%h expected ack=1 lat=1 data=00000000", cap_ack, cap_lat, cap_rd);
        end
        opb_xfer(1'b1, BASE + 32'd8, 4'hF, 32'h0);
        n_tests++;
        if (cap_rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_reg2: got %h expected 00000000", cap_rd); end
    endtask

    initial begin
        OPB_Rst      = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = 128'h0;
        bus_idle();
        repeat (3) @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        test_reset();
        test_full_write();
        test_byte_enable();
        test_pulse();
        test_read_only();
        test_held_select();
        test_out_of_range();
        test_outside_window();
        test_reset_mid_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single-register PPC-to-Simulink OPB slave: one OPB slave window holding N_REGS 32-bit software registers.
- Each register is independently configurable as read/write hold, self-clearing pulse, or read-only status fed from user logic.
- Byte-enable writes, readback, and a per-register one-cycle write strobe toward user logic.
- Sits on the PPC OPB in the XPS base system; user logic runs on OPB_Clk (single clock, no CDC).

Parameters:
- C_BASEADDR, 32'h01006000, first byte address of window
- C_HIGHADDR, 32'h010060FF, last byte address of window; must be ≥ C_BASEADDR + 4*N_REGS - 1
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
- N_REGS, 4, number of registers (1..64)
- PULSE_MASK, {N_REGS{1'b0}}, bit i = 1: register i self-clears one cycle after a write
- RO_MASK, {N_REGS{1'b0}}, bit i = 1: register i is read-only and reads user_data_in word i
- INIT_VAL, 32'h0, reset value of every RW register

Ports:
- OPB_Clk, in, 1: single clock for OPB and user side
- OPB_Rst, in, 1: reset, asynchronous, active-low
- OPB_ABus, in, [0:31]: address
- OPB_BE, in, [0:3]: byte enables; BE[0] selects DBus[0:7], which is user bits 31:24
- OPB_DBus, in, [0:31]: write data
- OPB_RNW, in, 1: 1 = read, 0 = write
- OPB_select, in, 1: transfer request
- OPB_seqAddr, in, 1: ignored
- Sl_DBus, out, [0:31]: read data; zero when not acking
- Sl_xferAck, out, 1: transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup, out, 1 each: tied 0
- user_data_out, out, 32*N_REGS: register i occupies bits [32i+31:32i]
- user_wr_stb, out, N_REGS: one-cycle pulse when register i is written
- user_data_in, in, 32*N_REGS: status words; only RO_MASK entries are used

Behaviour:
- Reset (OPB_Rst = 0, asynchronous):
  - RW registers = INIT_VAL; pulse registers = 0.
  - Sl_xferAck = 0, Sl_DBus = 0, user_wr_stb = 0.
  - FSM → IDLE.
- Hit: OPB_select = 1 and C_BASEADDR ≤ OPB_ABus ≤ C_HIGHADDR. Word index idx = (OPB_ABus - C_BASEADDR) >> 2; low 2 address bits are ignored.
- FSM: IDLE, ACK, RECOVER.
  - IDLE: on hit → ACK.
  - ACK: lasts 1 cycle, Sl_xferAck = 1 → RECOVER.
  - RECOVER: lasts 1 cycle, Sl_xferAck = 0 → IDLE. OPB_select is not sampled in RECOVER, so a held select is never double-acked.
- Latency: request sampled at edge t; Sl_xferAck and Sl_DBus valid in cycle t+1. Back-to-back transfers are acked every 3rd cycle at best.
- Write, committed on the edge entering ACK:
  - For each BE[k] = 1, byte k of register idx ← the corresponding DBus byte; BE = 0 bytes are unchanged.
  - user_wr_stb[idx] = 1 during the ACK cycle, including writes with BE = 0000.
  - Writes to RO registers are discarded, but still acked and still strobed.
- Pulse registers: the written value is visible on user_data_out for exactly the ACK cycle, then cleared to 0. Readback returns the current value (normally 0).
- Read: Sl_DBus during ACK = register idx, or user_data_in word idx for RO registers, captured on the edge entering ACK. Bit mapping: Sl_DBus[0] = bit 31.
- idx ≥ N_REGS but inside the window: acked (no bus timeout), read returns 0, write ignored, no strobe.
- Address outside the window: no ack, no state change.
- Reset asserted mid-transfer: ack is dropped immediately, the pending write is lost, and the FSM restarts in IDLE.
- OPB_RNW, OPB_ABus, OPB_BE and OPB_DBus are sampled only at the IDLE→ACK edge.

Test Plan:
- Reset then read all registers (N_REGS = 4) → every read returns 32'h0; each ack lasts exactly 1 cycle, 1 cycle after select.
- Write 32'hDEADBEEF to base+8 with BE = 1111, then read → user_data_out[95:64] = DEADBEEF, user_wr_stb = 4'b0100 for 1 cycle, readback DEADBEEF.
- Write 32'h11223344 to base+8 with BE = 0101 over DEADBEEF → register = DE22BE44.
- PULSE_MASK = 4'b0001; write 32'h5 to base+0 → user_data_out[31:0] = 5 for 1 cycle then 0; readback 0.
- RO_MASK = 4'b1000, user_data_in word 3 = 32'hCAFE0001; write 0 to base+12 then read → readback CAFE0001, strobe still pulses.
- Hold select for 6 cycles on one address → exactly 2 acks (cycles 1 and 4); access base+16 with N_REGS = 4 → acked, reads 0.
- Assert reset during ACK → Sl_xferAck = 0 immediately; all registers return to INIT_VAL.
